// File: rtl/parking_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : parking_pkg                                                    |
// | Shared definitions for the smart parking entry and register-manager      |
// | blocks: session state encoding, bus widths, token LFSR taps, and the     |
// | time nibble that steers a session to the P register.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package parking_pkg;

  localparam int TOKEN_W = 3;
  localparam int TIME_W  = 8;

  // Taps for x^3 + x^2 + 1: feedback is the XOR of bits 2 and 1.
  localparam logic [TOKEN_W-1:0] LFSR_TAPS = 3'b110;

  // time_data[7:4] equal to this value selects the P register downstream.
  localparam logic [3:0] P_NIBBLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    GRANT   = 3'd2,
    GAP     = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [TOKEN_W-1:0] lfsr_next(input logic [TOKEN_W-1:0] q);
    return {q[TOKEN_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/token_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : token_lfsr                                                     |
// | Free-running 3-bit Fibonacci LFSR (x^3+x^2+1, period 7). Advances on     |
// | every clock, so with a non-zero seed it never produces zero.             |
// | Ports   : clock  - system clock (rising edge)                            |
// |           reset  - synchronous, active-low; loads SEED                   |
// |           value  - current LFSR contents                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module token_lfsr
  import parking_pkg::*;
#(
  parameter logic [TOKEN_W-1:0] SEED = 3'b101
) (
  input  logic               clock,
  input  logic               reset,
  output logic [TOKEN_W-1:0] value
);

  logic [TOKEN_W-1:0] r_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= SEED;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign value = r_state;

endmodule
`default_nettype wire

// File: rtl/token_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : token_issuer                                                   |
// | Entry-side session controller. Draws a token when a car arrives, holds   |
// | request/system_token/time_data to the register manager, waits for the    |
// | P/Q enable, opens the gate on a grant, retries or locks out on timeout.  |
// | Ports   : clock, reset (sync, active-low)                                |
// |           car_arrive      - entry presence sensor (level)                |
// |           p_en, q_en      - register enables from the register manager   |
// |           request         - session active                               |
// |           system_token    - token of current session                     |
// |           time_data       - lot time counter                             |
// |           gate_open       - barrier drive                                |
// |           lot_p           - last grant went to P (1) or Q (0)            |
// |           session_fail    - one-cycle pulse per timed-out attempt        |
// |           lockout         - high while locked out                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module token_issuer
  import parking_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter int                 GATE_CYCLES    = 64,
  parameter int                 MAX_ATTEMPTS   = 3,
  parameter int                 TICK_DIV       = 16,
  parameter logic [TOKEN_W-1:0] LFSR_SEED      = 3'b101
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               car_arrive,
  input  logic               p_en,
  input  logic               q_en,
  output logic               request,
  output logic [TOKEN_W-1:0] system_token,
  output logic [TIME_W-1:0]  time_data,
  output logic               gate_open,
  output logic               lot_p,
  output logic               session_fail,
  output logic               lockout
);

  localparam int c_to_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_gate_w = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int c_pre_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_att_w  = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [c_to_w-1:0]   c_to_max   = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_gate_w-1:0] c_gate_max = c_gate_w'(GATE_CYCLES - 1);
  localparam logic [c_pre_w-1:0]  c_pre_max  = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_att_w-1:0]  c_max_att  = c_att_w'(MAX_ATTEMPTS);

  logic [TOKEN_W-1:0] w_lfsr;

  token_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (w_lfsr)
  );

  // Lot time base: runs in every state, independent of the session FSM.
  logic [c_pre_w-1:0] r_pre;
  logic [TIME_W-1:0]  r_time;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pre  <= '0;
      r_time <= '0;
    end else if (r_pre == c_pre_max) begin
      r_pre  <= '0;
      r_time <= r_time + 1'b1;
    end else begin
      r_pre  <= r_pre + 1'b1;
    end
  end

  // Session FSM state and registered outputs.
  state_t              r_state, w_state;
  logic                r_request, w_request;
  logic [TOKEN_W-1:0]  r_token, w_token;
  logic                r_gate, w_gate;
  logic                r_lot_p, w_lot_p;
  logic                r_fail, w_fail;
  logic                r_lockout, w_lockout;
  logic [c_to_w-1:0]   r_tcnt, w_tcnt;
  logic [c_gate_w-1:0] r_gcnt, w_gcnt;
  logic                r_gap, w_gap;
  logic [c_att_w-1:0]  r_attempts, w_attempts;
  logic                r_last_failed, w_last_failed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_request     <= 1'b0;
      r_token       <= '0;
      r_gate        <= 1'b0;
      r_lot_p       <= 1'b0;
      r_fail        <= 1'b0;
      r_lockout     <= 1'b0;
      r_tcnt        <= '0;
      r_gcnt        <= '0;
      r_gap         <= 1'b0;
      r_attempts    <= '0;
      r_last_failed <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_request     <= w_request;
      r_token       <= w_token;
      r_gate        <= w_gate;
      r_lot_p       <= w_lot_p;
      r_fail        <= w_fail;
      r_lockout     <= w_lockout;
      r_tcnt        <= w_tcnt;
      r_gcnt        <= w_gcnt;
      r_gap         <= w_gap;
      r_attempts    <= w_attempts;
      r_last_failed <= w_last_failed;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_request     = r_request;
    w_token       = r_token;
    w_gate        = r_gate;
    w_lot_p       = r_lot_p;
    w_fail        = 1'b0;
    w_lockout     = r_lockout;
    w_tcnt        = r_tcnt;
    w_gcnt        = r_gcnt;
    w_gap         = r_gap;
    w_attempts    = r_attempts;
    w_last_failed = r_last_failed;

    case (r_state)
      IDLE: begin
        if (car_arrive) begin
          w_state   = WAIT;
          w_request = 1'b1;
          w_token   = w_lfsr;
          w_tcnt    = '0;
        end
      end

      WAIT: begin
        w_tcnt = r_tcnt + 1'b1;
        // Abort beats grant, and a grant on the last cycle beats timeout.
        if (!car_arrive) begin
          w_state       = GAP;
          w_request     = 1'b0;
          w_gap         = 1'b0;
          w_last_failed = 1'b0;
        end else if (p_en || q_en) begin
          w_state = GRANT;
          w_gate  = 1'b1;
          w_lot_p = p_en;
          w_gcnt  = '0;
        end else if (r_tcnt == c_to_max) begin
          w_state       = GAP;
          w_fail        = 1'b1;
          w_request     = 1'b0;
          w_attempts    = r_attempts + 1'b1;
          w_last_failed = 1'b1;
          w_gap         = 1'b0;
        end
      end

      GRANT: begin
        w_gcnt = r_gcnt + 1'b1;
        if (r_gcnt == c_gate_max) begin
          w_state       = GAP;
          w_request     = 1'b0;
          w_gate        = 1'b0;
          w_attempts    = '0;
          w_last_failed = 1'b0;
          w_gap         = 1'b0;
        end
      end

      GAP: begin
        // Two cycles with request low so the far end sees both edges.
        w_gap = 1'b1;
        if (r_gap) begin
          if (r_attempts == c_max_att) begin
            w_state   = LOCKOUT;
            w_lockout = 1'b1;
          end else if (r_last_failed && car_arrive) begin
            w_state   = WAIT;
            w_request = 1'b1;
            w_token   = w_lfsr;
            w_tcnt    = '0;
          end else begin
            w_state = IDLE;
          end
        end
      end

      LOCKOUT: begin
        if (!car_arrive) begin
          w_state       = IDLE;
          w_lockout     = 1'b0;
          w_attempts    = '0;
          w_last_failed = 1'b0;
        end
      end

      default: w_state = IDLE;
    endcase
  end

  assign request      = r_request;
  assign system_token = r_token;
  assign time_data    = r_time;
  assign gate_open    = r_gate;
  assign lot_p        = r_lot_p;
  assign session_fail = r_fail;
  assign lockout      = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_token_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_token_issuer                                                |
// | Self-checking bench for token_issuer with short timing parameters.       |
// | Expected lot_p values are queued when a grant is driven and popped when  |
// | gate_open rises; tokens are compared against an independent LFSR model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_token_issuer;

  logic       clock      = 1'b0;
  logic       reset      = 1'b0;
  logic       car_arrive = 1'b0;
  logic       p_en       = 1'b0;
  logic       q_en       = 1'b0;
  logic       request;
  logic [2:0] system_token;
  logic [7:0] time_data;
  logic       gate_open;
  logic       lot_p;
  logic       session_fail;
  logic       lockout;

  int n_tests     = 0;
  int n_fail      = 0;
  int fail_pulses = 0;

  logic       exp_lot_q[$];
  logic [2:0] m_lfsr    = 3'b101;
  logic [2:0] m_prev    = 3'b101;
  logic       prev_req  = 1'b0;
  logic       prev_gate = 1'b0;

  always #5 clock = ~clock;

  token_issuer #(
    .TIMEOUT_CYCLES (8),
    .GATE_CYCLES    (4),
    .MAX_ATTEMPTS   (3),
    .TICK_DIV       (2),
    .LFSR_SEED      (3'b101)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .car_arrive   (car_arrive),
    .p_en         (p_en),
    .q_en         (q_en),
    .request      (request),
    .system_token (system_token),
    .time_data    (time_data),
    .gate_open    (gate_open),
    .lot_p        (lot_p),
    .session_fail (session_fail),
    .lockout      (lockout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference token source; m_prev is the value the LFSR held before the last edge.
  always @(posedge clock) begin
    m_prev <= m_lfsr;
    if (!reset) m_lfsr <= 3'b101;
    else        m_lfsr <= {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
  end

  // Monitor: token on every session start, scoreboard on every gate opening.
  always @(negedge clock) begin
    if (request && !prev_req) begin
      check_eq("token_vs_model", system_token, m_prev);
      check_eq("token_nonzero", system_token != 3'b000, 1);
    end
    if (gate_open && !prev_gate) begin
      check_eq("grant_expected", exp_lot_q.size() != 0, 1);
      if (exp_lot_q.size() != 0) check_eq("lot_p_sb", lot_p, exp_lot_q.pop_front());
    end
    if (session_fail) fail_pulses++;
    prev_req  <= request;
    prev_gate <= gate_open;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic start_session(input string tag);
    car_arrive = 1'b1;
    step(1);
    check_eq(tag, request, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a car present, then release.
    car_arrive = 1'b1;
    step(3);
    check_eq("rst_request", request, 0);
    check_eq("rst_token", system_token, 0);
    check_eq("rst_time", time_data, 0);
    check_eq("rst_gate", gate_open, 0);
    check_eq("rst_lot_p", lot_p, 0);
    check_eq("rst_fail", session_fail, 0);
    check_eq("rst_lockout", lockout, 0);
    reset = 1'b1;
    step(1);
    check_eq("t1_request", request, 1);
    check_eq("t1_token_seed", system_token, 3'b101);
    car_arrive = 1'b0;
    step(1);
    check_eq("t1_abort_req", request, 0);
    step(3);

    // 2: P grant on WAIT cycle 3.
    start_session("t2_req");
    step(2);
    p_en = 1'b1;
    exp_lot_q.push_back(1'b1);
    step(1);
    p_en = 1'b0;
    check_eq("t2_gate_rise", gate_open, 1);
    check_eq("t2_lot_p", lot_p, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("t2_gate_held", gate_open, 1);
      check_eq("t2_req_held", request, 1);
    end
    step(1);
    check_eq("t2_gate_fall", gate_open, 0);
    check_eq("t2_req_fall", request, 0);
    car_arrive = 1'b0;
    step(1);
    check_eq("t2_gap_req", request, 0);
    check_eq("t2_no_fail", fail_pulses, 0);
    step(2);

    // 3: three timeouts lead to lockout.
    start_session("t3_req");
    for (int a = 0; a < 3; a++) begin
      step(7);
      check_eq("t3_wait_req", request, 1);
      check_eq("t3_wait_nofail", session_fail, 0);
      step(1);
      check_eq("t3_fail_pulse", session_fail, 1);
      check_eq("t3_fail_req", request, 0);
      step(1);
      check_eq("t3_pulse_width", session_fail, 0);
      check_eq("t3_gap_req", request, 0);
      step(1);
      if (a < 2) begin
        check_eq("t3_retry_req", request, 1);
      end else begin
        check_eq("t3_lockout", lockout, 1);
        check_eq("t3_lock_req", request, 0);
      end
    end
    step(3);
    check_eq("t3_lock_held", lockout, 1);
    check_eq("t3_lock_req_held", request, 0);
    check_eq("t3_fail_count", fail_pulses, 3);
    car_arrive = 1'b0;
    step(1);
    check_eq("t3_unlock", lockout, 0);

    // 4: Q grant on the timeout cycle wins over the fail.
    start_session("t4_req");
    step(7);
    q_en = 1'b1;
    exp_lot_q.push_back(1'b0);
    step(1);
    q_en = 1'b0;
    check_eq("t4_gate", gate_open, 1);
    check_eq("t4_lot_q", lot_p, 0);
    check_eq("t4_no_fail", session_fail, 0);
    check_eq("t4_req", request, 1);
    step(4);
    check_eq("t4_gate_fall", gate_open, 0);
    car_arrive = 1'b0;
    p_en = 1'b1;
    step(3);
    check_eq("t4_p_ignored", gate_open, 0);
    p_en = 1'b0;
    check_eq("t4_fail_count", fail_pulses, 3);

    // 5: both enables -> P; then an abort mid-WAIT.
    start_session("t5_req");
    p_en = 1'b1;
    q_en = 1'b1;
    exp_lot_q.push_back(1'b1);
    step(1);
    p_en = 1'b0;
    q_en = 1'b0;
    check_eq("t5_both_lot_p", lot_p, 1);
    step(4);
    check_eq("t5_gate_fall", gate_open, 0);
    car_arrive = 1'b0;
    step(3);
    start_session("t5_req2");
    step(2);
    car_arrive = 1'b0;
    step(1);
    check_eq("t5_abort_req", request, 0);
    check_eq("t5_abort_nofail", session_fail, 0);
    step(2);
    car_arrive = 1'b1;
    step(1);
    check_eq("t5_idle_restart", request, 1);
    car_arrive = 1'b0;
    step(4);
    check_eq("t5_fail_count", fail_pulses, 3);

    // 6: time counter wrap from a fresh reset, then reset mid-GRANT.
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    check_eq("t6_time_1", time_data, 8'h01);
    step(508);
    check_eq("t6_time_ff", time_data, 8'hFF);
    step(1);
    check_eq("t6_time_ff_hold", time_data, 8'hFF);
    step(1);
    check_eq("t6_time_wrap", time_data, 8'h00);
    start_session("t6_req");
    p_en = 1'b1;
    exp_lot_q.push_back(1'b1);
    step(1);
    p_en = 1'b0;
    check_eq("t6_gate", gate_open, 1);
    step(1);
    reset = 1'b0;
    step(1);
    check_eq("t6_rst_gate", gate_open, 0);
    check_eq("t6_rst_time", time_data, 0);
    check_eq("t6_rst_req", request, 0);
    reset = 1'b1;
    car_arrive = 1'b0;
    step(2);
    check_eq("sb_drained", exp_lot_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
